reaction_timer_core: RTL and testbench

//  Downstream consumer of the 1 kHz divided clock. Edge-detects that clock into a one-CLK ms tick and runs
//  one reaction-time trial: pseudo-random delay, light GO LED, count ms in BCD until the player presses REACT.

---
 rtl/reaction_timer_core_pkg.sv | 38 +++
 rtl/reaction_timer_core_if.sv | 27 ++
 rtl/reaction_timer_core_bcd_counter4.sv | 53 +++++
 rtl/reaction_timer_core.sv | 141 ++++++++++++++
 tb/tb_reaction_timer_core.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reaction_timer_core_pkg - FSM states, BCD/LFSR constants and helpers       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package reaction_timer_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_GO      = 3'd2,
    ST_DONE    = 3'd3,
    ST_EARLY   = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;
  localparam int LFSR_W      = 16;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [BCD_W-1:0] to_bcd4(input int unsigned value);
    logic [BCD_W-1:0] r;
    r[3:0]   = 4'(value % 10);
    r[7:4]   = 4'((value / 10) % 10);
    r[11:8]  = 4'((value / 100) % 10);
    r[15:12] = 4'((value / 1000) % 10);
    return r;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reaction_timer_core_if - ms clock, buttons and display/status outputs      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reaction_timer_core_if;
  logic        ms_clk;
  logic        start;
  logic        react;
  logic        led_go;
  logic [15:0] bcd_ms;
  logic        result_valid;
  logic        early;
  logic        timeout;
  logic        busy;

  modport master (
    output ms_clk, start, react,
    input  led_go, bcd_ms, result_valid, early, timeout, busy
  );

  modport slave (
    input  ms_clk, start, react,
    output led_go, bcd_ms, result_valid, early, timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/reaction_timer_core_bcd_counter4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reaction_timer_core_bcd_counter4 - 4-digit BCD counter with ceiling flag   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reaction_timer_core_bcd_counter4
  import reaction_timer_core_pkg::*;
#(
  parameter int unsigned MAX_MS = 9999
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic [BCD_W-1:0]      value,
  output logic                  at_max
);

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd4(MAX_MS);

  logic [BCD_W-1:0] value_inc;
  logic             carry;

  // Ripple decimal carry: each 9 wraps to 0 and passes the carry upward
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (carry) begin
        if (value[d*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
          value_inc[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
        end else begin
          value_inc[d*BCD_DIGIT_W +: BCD_DIGIT_W] = value[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value_inc;
    end
  end

  assign at_max = (value == MAX_BCD);

endmodule
`default_nettype wire

// File: rtl/reaction_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reaction_timer_core - one reaction-time trial: random delay, GO, BCD ms    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reaction_timer_core
  import reaction_timer_core_pkg::*;
#(
  parameter int unsigned       MIN_DELAY_MS = 1000,
  parameter int unsigned       RAND_BITS    = 11,
  parameter int unsigned       MAX_MS       = 9999,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned       SYNC_STAGES  = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  reaction_timer_core_if.slave   bus
);

  localparam int DELAY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS));

  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] react_sync;
  logic                   start_q;
  logic                   react_q;
  logic                   ms_clk_q;
  logic [LFSR_W-1:0]      lfsr;

  state_t                 state;
  logic [DELAY_W-1:0]     delay_cnt;
  logic                   led_go_q;
  logic                   busy_q;
  logic                   result_valid_q;
  logic                   early_q;
  logic                   timeout_q;

  logic                   start_p;
  logic                   react_p;
  logic                   ms_tick;
  logic                   idle_like;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      react_sync <= '0;
      start_q    <= 1'b0;
      react_q    <= 1'b0;
      ms_clk_q   <= 1'b0;
      lfsr       <= LFSR_SEED;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], bus.start};
      react_sync <= {react_sync[SYNC_STAGES-2:0], bus.react};
      start_q    <= start_sync[SYNC_STAGES-1];
      react_q    <= react_sync[SYNC_STAGES-1];
      ms_clk_q   <= bus.ms_clk;
      lfsr       <= lfsr_next(lfsr);
    end
  end

  // ms_clk is already in the clk domain, so its rise is used unsynchronised
  assign ms_tick   = bus.ms_clk & ~ms_clk_q;
  assign start_p   = start_sync[SYNC_STAGES-1] & ~start_q;
  assign react_p   = react_sync[SYNC_STAGES-1] & ~react_q;
  assign idle_like = (state != ST_WAIT) && (state != ST_GO);
  assign cnt_clr   = idle_like && start_p;
  assign cnt_inc   = (state == ST_GO) && ms_tick && !react_p && !at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      delay_cnt      <= '0;
      led_go_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (react_p) begin
            state   <= ST_EARLY;
            early_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (ms_tick) begin
            delay_cnt <= delay_cnt - DELAY_W'(1);
            if (delay_cnt == DELAY_W'(1)) begin
              state    <= ST_GO;
              led_go_q <= 1'b1;
            end
          end
        end
        ST_GO: begin
          // A press on the same cycle as a tick wins; the counter is not bumped
          if (react_p) begin
            state          <= ST_DONE;
            led_go_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
          end else if (ms_tick && at_max) begin
            state     <= ST_TIMEOUT;
            led_go_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          if (start_p) begin
            state          <= ST_WAIT;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            delay_cnt      <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr[RAND_BITS-1:0]);
          end
        end
      endcase
    end
  end

  reaction_timer_core_bcd_counter4 #(
    .MAX_MS (MAX_MS)
  ) u_bcd_counter4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .value  (bus.bcd_ms),
    .at_max (at_max)
  );

  assign bus.led_go       = led_go_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.early        = early_q;
  assign bus.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reaction_timer_core - randomized trials against a timing-level model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reaction_timer_core;

  localparam int          MIN_DELAY_MS = 3;
  localparam int          RAND_BITS    = 2;
  localparam int          MAX_MS       = 25;
  localparam int          SYNC_STAGES  = 2;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam int          MS_PERIOD    = 10;
  localparam int          K_DONE = 0, K_EARLY = 1, K_TIMEOUT = 2;

  typedef struct {
    int kind;
    int count;
    int go_edge;
    int end_edge;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   rel   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  reaction_timer_core_if bus();

  reaction_timer_core #(
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .RAND_BITS    (RAND_BITS),
    .MAX_MS       (MAX_MS),
    .LFSR_SEED    (LFSR_SEED),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ms_clk rises just before edges with cyc % 10 == 1, so those edges carry ms_tick
  always @(negedge clk) bus.ms_clk = ((cyc % MS_PERIOD) < 5);

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int to_bcd_ref(input int n);
    return ((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10);
  endfunction

  // Register contents seen by edge number e: one step per edge since reset release
  function automatic logic [15:0] lfsr_before(input int e);
    logic [15:0] s = LFSR_SEED;
    for (int i = 0; i < e - 1 - rel; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  // Monitor: per-tick count check in GO, and scoreboard pop on each new result
  bit prev_busy, prev_led, prev_out, led_seen;
  int g_obs;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 0; prev_led = 0; prev_out = 0;
    end else begin
      if (bus.busy && !prev_busy) begin
        chk("wait_flags_clear", {bus.early, bus.result_valid, bus.timeout}, 0);
        chk("wait_bcd_clear", bus.bcd_ms, 0);
        led_seen = 0;
      end
      if (bus.led_go && !prev_led) begin
        g_obs    = cyc;
        led_seen = 1;
      end
      if (bus.led_go && prev_led && (cyc % MS_PERIOD) == 1)
        chk("go_count", bus.bcd_ms, to_bcd_ref((cyc - g_obs) / MS_PERIOD));
      if ((bus.result_valid || bus.early || bus.timeout) && !prev_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("result_valid", bus.result_valid, (m_e.kind == K_DONE) ? 1 : 0);
          chk("early", bus.early, (m_e.kind == K_EARLY) ? 1 : 0);
          chk("timeout", bus.timeout, (m_e.kind == K_TIMEOUT) ? 1 : 0);
          chk("bcd_ms", bus.bcd_ms, to_bcd_ref(m_e.count));
          chk("busy_after", bus.busy, 0);
          chk("led_go_after", bus.led_go, 0);
          chk("end_edge", cyc, m_e.end_edge);
          if (m_e.kind == K_EARLY) chk("early_no_go", led_seen, 0);
          else                     chk("go_edge", g_obs, m_e.go_edge);
        end
      end
      prev_busy = bus.busy;
      prev_led  = bus.led_go;
      prev_out  = bus.result_valid || bus.early || bus.timeout;
    end
  end

  // Start pin considered raised in the negedge window of cycle c; FSM acts at edge c+SYNC_STAGES+1
  task automatic trial(input int c, input int kind, input int k, input int off,
                       input bit stray, input bit held, input bit push, input int stop_go);
    int W, D, t1, G, T, R, n, st, stop_at;
    exp_t e;
    W  = c + SYNC_STAGES + 1;
    D  = MIN_DELAY_MS + (int'(lfsr_before(W)) % (1 << RAND_BITS));
    t1 = W + 1;
    while ((t1 % MS_PERIOD) != 1) t1++;
    G  = t1 + MS_PERIOD * (D - 1);
    T  = G + MS_PERIOD * (MAX_MS + 1);
    R  = -100;
    st = -100;
    if (kind == K_EARLY) begin
      R = W + 1 + int'($urandom_range(0, G - W - 1));
      e = '{K_EARLY, 0, -1, R};
    end else if (kind == K_DONE) begin
      R = G + MS_PERIOD * k + off;
      n = 0;
      for (int t = G + 1; t < R; t++) if ((t % MS_PERIOD) == 1) n++;
      if (n > MAX_MS) e = '{K_TIMEOUT, MAX_MS, G, T};
      else            e = '{K_DONE, n, G, R};
    end else begin
      e = '{K_TIMEOUT, MAX_MS, G, T};
    end
    if (stray && kind != K_EARLY) st = G + 1;
    stop_at = (stop_go >= 0) ? G + MS_PERIOD * stop_go + 3 : e.end_edge + 5;
    if (push) sb.push_back(e);
    bus.start = 1'b1;
    while (cyc < stop_at) begin
      @(negedge clk);
      bus.start = held || (cyc >= c && cyc < c + 4) || (cyc >= st && cyc < st + 4);
      bus.react = (cyc >= R - 3 && cyc < R + 1);
    end
    bus.react = 1'b0;
    if (!held) bus.start = 1'b0;
    if (push) begin
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  initial begin
    bus.start = 1'b1;
    bus.react = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led_go", bus.led_go, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_early", bus.early, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_bcd", bus.bcd_ms, 0);

    // Start held through reset release: exactly one trial, which times out
    release_reset();
    bus.react = 1'b0;
    trial(rel, K_TIMEOUT, 0, 0, 0, 1, 1, -1);
    repeat (30) @(negedge clk);
    chk("held_start_one_trial", bus.busy, 0);
    chk("held_start_timeout", bus.timeout, 1);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);

    // Choose the start cycle so that the delay draw is MIN+2, react 7 ms into GO
    for (int i = 0; i < 64 && (lfsr_before(cyc + SYNC_STAGES + 1) & 16'h3) != 16'h2; i++)
      @(negedge clk);
    trial(cyc, K_DONE, 7, 5, 0, 0, 1, -1);
    repeat (5) @(negedge clk);
    trial(cyc, K_EARLY, 0, 0, 0, 0, 1, -1);
    repeat (5) @(negedge clk);
    trial(cyc, K_TIMEOUT, 0, 0, 0, 0, 1, -1);
    repeat (5) @(negedge clk);
    trial(cyc, K_DONE, 5, 0, 1, 0, 1, -1);              // react aligned with tick at 0004
    repeat (5) @(negedge clk);
    trial(cyc, K_DONE, MAX_MS + 1, 0, 0, 0, 1, -1);     // react on the ceiling tick beats timeout
    repeat (5) @(negedge clk);
    trial(cyc, K_DONE, MAX_MS + 1, 3, 0, 0, 1, -1);     // react after timeout is ignored
    repeat (5) @(negedge clk);

    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      trial(cyc, kind, int'($urandom_range(1, MAX_MS + 2)), int'($urandom_range(0, 9)),
            bit'($urandom_range(0, 1)), 0, 1, -1);
      repeat (int'($urandom_range(4, 12))) @(negedge clk);
    end

    // Reset mid-GO at count 0012
    trial(cyc, K_TIMEOUT, 0, 0, 0, 0, 0, 12);
    chk("pre_reset_bcd", bus.bcd_ms, to_bcd_ref(12));
    chk("pre_reset_led_go", bus.led_go, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led_go", bus.led_go, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_bcd", bus.bcd_ms, 0);
    chk("async_rst_flags", {bus.result_valid, bus.early, bus.timeout}, 0);
    repeat (2) @(negedge clk);
    release_reset();
    repeat (40) @(negedge clk);
    chk("idle_after_reset_busy", bus.busy, 0);
    chk("idle_after_reset_bcd", bus.bcd_ms, 0);
    trial(cyc, K_DONE, 3, 7, 0, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
